hs32_wb_bridge: RTL and testbench

//  Wishbone classic slave front end for the HS32 core's shared memory bus.

---
 rtl/hs32_wb_bridge_pkg.sv | 25 ++
 rtl/hs32_byte_merge.sv | 22 ++
 rtl/hs32_wb_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_hs32_wb_bridge.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_wb_bridge_pkg.sv
// Shared types and constants for the HS32 wishbone bridge.
// State encodings are 3-bit to match the existing bus-side tooling.
package hs32_wb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_WR     = 3'd4,
    ST_RESP   = 3'd5,
    ST_DRAIN  = 3'd6
  } wbb_state_e;

  localparam logic [31:0] HS32_WBB_ERR_DATA = 32'hDEAD_C0DE;
  localparam logic [3:0]  SEL_NONE          = 4'h0;
  localparam logic [3:0]  SEL_FULL          = 4'hF;

  // States with an internal transaction outstanding.
  function automatic logic is_waiting(input wbb_state_e st);
    return (st == ST_RD) || (st == ST_WR) || (st == ST_RMW_RD) ||
           (st == ST_RMW_WR) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/hs32_byte_merge.sv
// Byte-lane merge for read-modify-write: selected lanes come from the write
// data, the remaining lanes keep the word read back from the internal bus.
module hs32_byte_merge (
  input  logic [31:0] rdat,
  input  logic [31:0] wdat,
  input  logic [3:0]  sel,
  output logic [31:0] merged
);

  // Per-lane select between write data and read-back data.
  always_comb begin
    merged = 32'h0000_0000;
    for (int n = 0; n < 4; n++) begin
      if (sel[n]) begin
        merged[8*n +: 8] = wdat[8*n +: 8];
      end else begin
        merged[8*n +: 8] = rdat[8*n +: 8];
      end
    end
  end

endmodule

// File: rtl/hs32_wb_bridge.sv
// Wishbone classic slave to HS32 internal word bus, with RMW for partial writes.
// Optional transaction timeout is built when HS32_WB_TIMEOUT_EN is defined.
module hs32_wb_bridge
  import hs32_wb_bridge_pkg::*;
#(
  parameter int          TIMEOUT_W = 8,
  parameter logic [31:0] ERR_DATA  = HS32_WBB_ERR_DATA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        m_stb,
  output logic        m_rw,
  output logic [31:0] m_addr,
  output logic [31:0] m_dtw,
  input  logic [31:0] m_dtr,
  input  logic        m_ack,
  output logic        busy,
  output logic        timeout
);

  wbb_state_e  state_r, state_s;
  logic        ack_r, ack_s;
  logic [31:0] dat_o_r, dat_o_s;
  logic        stb_r, stb_s;
  logic        rw_r, rw_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] dtw_r, dtw_s;
  logic [31:0] wdat_r, wdat_s;
  logic [3:0]  sel_r, sel_s;
  logic        busy_r;
  logic        tmo_r, tmo_s;
  logic        tmo_hit_s;
  logic [31:0] merged_s;
  logic        adr_unused_s;

  assign adr_unused_s = ^wbs_adr_i[1:0];

  hs32_byte_merge u_merge (
    .rdat   (m_dtr),
    .wdat   (wdat_r),
    .sel    (sel_r),
    .merged (merged_s)
  );

`ifdef HS32_WB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] cnt_r;

  // Wait counter: restarts with each internal request, advances while no ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {TIMEOUT_W{1'b0}};
    end else if (stb_s) begin
      cnt_r <= {TIMEOUT_W{1'b0}};
    end else if (is_waiting(state_r) && !m_ack) begin
      cnt_r <= cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Fires on the cycle the counter would reach its all-ones value.
  assign tmo_hit_s = is_waiting(state_r) && !m_ack && (cnt_r == CNT_LAST);
`else
  // Without the counter a stalled internal bus simply holds the bridge busy.
  assign tmo_hit_s = 1'b0 && (TIMEOUT_W > 0);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    ack_s   = 1'b0;
    stb_s   = 1'b0;
    rw_s    = rw_r;
    addr_s  = addr_r;
    dtw_s   = dtw_r;
    dat_o_s = dat_o_r;
    wdat_s  = wdat_r;
    sel_s   = sel_r;
    tmo_s   = tmo_r;
    case (state_r)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          addr_s = {wbs_adr_i[31:2], 2'b00};
          wdat_s = wbs_dat_i;
          sel_s  = wbs_sel_i;
          if (!wbs_we_i) begin
            state_s = ST_RD;
            stb_s   = 1'b1;
            rw_s    = 1'b0;
          end else if (wbs_sel_i == SEL_FULL) begin
            state_s = ST_WR;
            stb_s   = 1'b1;
            rw_s    = 1'b1;
            dtw_s   = wbs_dat_i;
          end else if (wbs_sel_i == SEL_NONE) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_RMW_RD;
            stb_s   = 1'b1;
            rw_s    = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD, ST_WR, ST_RMW_RD, ST_RMW_WR: begin
        if (m_ack) begin
          if (!wbs_cyc_i) begin
            state_s = ST_IDLE;
          end else if (state_r == ST_RMW_RD) begin
            state_s = ST_RMW_WR;
            stb_s   = 1'b1;
            rw_s    = 1'b1;
            dtw_s   = merged_s;
          end else begin
            state_s = ST_RESP;
            ack_s   = 1'b1;
            if (state_r == ST_RD) begin
              dat_o_s = m_dtr;
            end else begin
              dat_o_s = dat_o_r;
            end
          end
        end else if (tmo_hit_s) begin
          tmo_s = 1'b1;
          if (!wbs_cyc_i) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_RESP;
            ack_s   = 1'b1;
            if (state_r == ST_RD) begin
              dat_o_s = ERR_DATA;
            end else begin
              dat_o_s = dat_o_r;
            end
          end
        end else if (!wbs_cyc_i) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = state_r;
        end
      end
      // A write with no lanes enabled spends one extra cycle here before acking.
      ST_RESP: begin
        if (ack_r) begin
          state_s = ST_IDLE;
        end else begin
          ack_s   = 1'b1;
          state_s = ST_RESP;
        end
      end
      ST_DRAIN: begin
        if (m_ack) begin
          state_s = ST_IDLE;
        end else if (tmo_hit_s) begin
          tmo_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      ack_r   <= 1'b0;
      dat_o_r <= 32'h0000_0000;
      stb_r   <= 1'b0;
      rw_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      dtw_r   <= 32'h0000_0000;
      wdat_r  <= 32'h0000_0000;
      sel_r   <= 4'h0;
      busy_r  <= 1'b0;
      tmo_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      ack_r   <= ack_s;
      dat_o_r <= dat_o_s;
      stb_r   <= stb_s;
      rw_r    <= rw_s;
      addr_r  <= addr_s;
      dtw_r   <= dtw_s;
      wdat_r  <= wdat_s;
      sel_r   <= sel_s;
      busy_r  <= (state_s != ST_IDLE);
      tmo_r   <= tmo_s;
    end
  end

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_o_r;
  assign m_stb     = stb_r;
  assign m_rw      = rw_r;
  assign m_addr    = addr_r;
  assign m_dtw     = dtw_r;
  assign busy      = busy_r;
  assign timeout   = tmo_r;

endmodule

// File: tb/tb_hs32_wb_bridge.sv
// Directed self-checking bench for hs32_wb_bridge.
// The timeout scenario runs only when HS32_WB_TIMEOUT_EN is defined.
module tb_hs32_wb_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        m_stb, m_rw;
  logic [31:0] m_addr, m_dtw, m_dtr;
  logic        m_ack;
  logic        busy, timeout;

  int checks = 0;
  int failures = 0;
  int stb_pulses = 0;
  int ack_pulses = 0;

  hs32_wb_bridge #(.TIMEOUT_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .m_stb     (m_stb),
    .m_rw      (m_rw),
    .m_addr    (m_addr),
    .m_dtw     (m_dtw),
    .m_dtr     (m_dtr),
    .m_ack     (m_ack),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_stb) stb_pulses <= stb_pulses + 1;
    if (wbs_ack_o) ack_pulses <= ack_pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
  endtask

  task automatic release_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({wbs_ack_o, m_stb, m_rw, busy, timeout} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {wbs_ack_o, m_stb, m_rw, busy, timeout});
    end
    checks++;
    if ({wbs_dat_o, m_addr, m_dtw} !== 96'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {wbs_dat_o, m_addr, m_dtw});
    end
  endtask

  task automatic test_read();
    int s0, a0;
    s0 = stb_pulses; a0 = ack_pulses;
    request(1'b0, 4'h3, 32'h0000_0106, 32'h0);
    tick();
    checks++;
    if ({m_stb, m_rw, busy} !== 3'b101 || m_addr !== 32'h0000_0104) begin
      failures++; $display("FAIL rd_issue got stb/rw/busy=%b addr=%h exp=101 addr=00000104", {m_stb, m_rw, busy}, m_addr);
    end
    tick(); tick();
    checks++;
    if ({m_stb, wbs_ack_o} !== 2'b00) begin
      failures++; $display("FAIL rd_wait got stb/ack=%b exp=00", {m_stb, wbs_ack_o});
    end
    tick();
    m_ack = 1'b1; m_dtr = 32'h1234_5678;
    tick();
    m_ack = 1'b0; m_dtr = 32'h0;
    checks++;
    if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h1234_5678) begin
      failures++; $display("FAIL rd_resp got ack=%b dat=%h exp ack=1 dat=12345678", wbs_ack_o, wbs_dat_o);
    end
    release_bus();
    tick();
    checks++;
    if ({wbs_ack_o, busy} !== 2'b00 || stb_pulses - s0 !== 1 || ack_pulses - a0 !== 1) begin
      failures++; $display("FAIL rd_done got ack/busy=%b stbs=%0d acks=%0d exp 00 1 1", {wbs_ack_o, busy}, stb_pulses - s0, ack_pulses - a0);
    end
  endtask

  task automatic test_full_write();
    int s0, a0;
    s0 = stb_pulses; a0 = ack_pulses;
    request(1'b1, 4'hF, 32'h0000_0200, 32'hCAFE_BABE);
    tick();
    checks++;
    if ({m_stb, m_rw} !== 2'b11 || m_dtw !== 32'hCAFE_BABE || m_addr !== 32'h0000_0200) begin
      failures++; $display("FAIL wr_issue got stb/rw=%b dtw=%h addr=%h exp 11 cafebabe 00000200", {m_stb, m_rw}, m_dtw, m_addr);
    end
    tick();
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    checks++;
    if (wbs_ack_o !== 1'b1) begin
      failures++; $display("FAIL wr_ack got=%b exp=1", wbs_ack_o);
    end
    release_bus();
    repeat (3) tick();
    checks++;
    if (stb_pulses - s0 !== 1 || ack_pulses - a0 !== 1) begin
      failures++; $display("FAIL wr_pulses got stbs=%0d acks=%0d exp 1 1", stb_pulses - s0, ack_pulses - a0);
    end
  endtask

  task automatic test_rmw();
    int s0, a0;
    s0 = stb_pulses; a0 = ack_pulses;
    request(1'b1, 4'b0101, 32'h0000_0300, 32'hAABB_CCDD);
    tick();
    checks++;
    if ({m_stb, m_rw} !== 2'b10) begin
      failures++; $display("FAIL rmw_rd got stb/rw=%b exp=10", {m_stb, m_rw});
    end
    tick();
    m_ack = 1'b1; m_dtr = 32'h1122_3344;
    tick();
    m_ack = 1'b0; m_dtr = 32'h0;
    checks++;
    if ({m_stb, m_rw} !== 2'b11 || m_dtw !== 32'h11BB_33DD) begin
      failures++; $display("FAIL rmw_wr got stb/rw=%b dtw=%h exp 11 11bb33dd", {m_stb, m_rw}, m_dtw);
    end
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    checks++;
    if (wbs_ack_o !== 1'b1) begin
      failures++; $display("FAIL rmw_ack got=%b exp=1", wbs_ack_o);
    end
    release_bus();
    repeat (2) tick();
    checks++;
    if (stb_pulses - s0 !== 2 || ack_pulses - a0 !== 1 || busy !== 1'b0) begin
      failures++; $display("FAIL rmw_pulses got stbs=%0d acks=%0d busy=%b exp 2 1 0", stb_pulses - s0, ack_pulses - a0, busy);
    end
  endtask

  task automatic test_abort();
    int a0;
    a0 = ack_pulses;
    request(1'b0, 4'hF, 32'h0000_0400, 32'h0);
    tick();
    release_bus();
    tick();
    checks++;
    if ({busy, wbs_ack_o} !== 2'b10) begin
      failures++; $display("FAIL abort_drain got busy/ack=%b exp=10", {busy, wbs_ack_o});
    end
    tick(); tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL abort_hold got busy=%b exp=1", busy);
    end
    m_ack = 1'b1; m_dtr = 32'h5555_AAAA;
    tick();
    m_ack = 1'b0; m_dtr = 32'h0;
    checks++;
    if ({busy, wbs_ack_o} !== 2'b00 || ack_pulses - a0 !== 0) begin
      failures++; $display("FAIL abort_end got busy/ack=%b acks=%0d exp 00 0", {busy, wbs_ack_o}, ack_pulses - a0);
    end
    request(1'b0, 4'hF, 32'h0000_0108, 32'h0);
    tick();
    m_ack = 1'b1; m_dtr = 32'h0BAD_F00D;
    tick();
    m_ack = 1'b0; m_dtr = 32'h0;
    checks++;
    if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h0BAD_F00D || m_addr !== 32'h0000_0108) begin
      failures++; $display("FAIL abort_next got ack=%b dat=%h addr=%h exp 1 0badf00d 00000108", wbs_ack_o, wbs_dat_o, m_addr);
    end
    release_bus();
    tick();
  endtask

  task automatic test_back_to_back();
    request(1'b0, 4'hF, 32'h0000_0010, 32'h0);
    tick();
    m_ack = 1'b1; m_dtr = 32'hA5A5_0001;
    tick();
    m_ack = 1'b0; m_dtr = 32'h0;
    checks++;
    if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'hA5A5_0001) begin
      failures++; $display("FAIL b2b_first got ack=%b dat=%h exp 1 a5a50001", wbs_ack_o, wbs_dat_o);
    end
    request(1'b1, 4'hF, 32'h0000_0014, 32'h7777_8888);
    tick();
    checks++;
    if (m_stb !== 1'b0 || wbs_ack_o !== 1'b0) begin
      failures++; $display("FAIL b2b_idle got stb/ack=%b exp=00", {m_stb, wbs_ack_o});
    end
    tick();
    checks++;
    if ({m_stb, m_rw} !== 2'b11 || m_addr !== 32'h0000_0014 || m_dtw !== 32'h7777_8888) begin
      failures++; $display("FAIL b2b_second got stb/rw=%b addr=%h dtw=%h exp 11 00000014 77778888", {m_stb, m_rw}, m_addr, m_dtw);
    end
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    release_bus();
    tick();
  endtask

  task automatic test_sel_zero_and_reset();
    int s0;
    s0 = stb_pulses;
    request(1'b1, 4'h0, 32'h0000_0600, 32'h1357_9BDF);
    tick();
    checks++;
    if ({m_stb, wbs_ack_o, busy} !== 3'b001) begin
      failures++; $display("FAIL sel0_first got stb/ack/busy=%b exp=001", {m_stb, wbs_ack_o, busy});
    end
    tick();
    checks++;
    if (wbs_ack_o !== 1'b1) begin
      failures++; $display("FAIL sel0_ack got=%b exp=1", wbs_ack_o);
    end
    release_bus();
    tick();
    checks++;
    if ({wbs_ack_o, busy} !== 2'b00 || stb_pulses - s0 !== 0) begin
      failures++; $display("FAIL sel0_done got ack/busy=%b stbs=%0d exp 00 0", {wbs_ack_o, busy}, stb_pulses - s0);
    end
    request(1'b1, 4'b0011, 32'h0000_0700, 32'hFFFF_FFFF);
    tick(); tick();
    m_ack = 1'b1; m_dtr = 32'h0102_0304;
    tick();
    m_ack = 1'b0; m_dtr = 32'h0;
    checks++;
    if (m_stb !== 1'b1 || m_dtw !== 32'h0102_FFFF) begin
      failures++; $display("FAIL rst_pre got stb=%b dtw=%h exp 1 0102ffff", m_stb, m_dtw);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({wbs_ack_o, m_stb, m_rw, busy, timeout} !== 5'b0 || {wbs_dat_o, m_addr, m_dtw} !== 96'h0) begin
      failures++; $display("FAIL rst_mid got flags=%b data=%h exp 0", {wbs_ack_o, m_stb, m_rw, busy, timeout}, {wbs_dat_o, m_addr, m_dtw});
    end
    release_bus();
    tick();
    reset_n = 1'b1;
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    tick();
    checks++;
    if ({wbs_ack_o, m_stb, busy} !== 3'b000) begin
      failures++; $display("FAIL rst_late_ack got ack/stb/busy=%b exp=000", {wbs_ack_o, m_stb, busy});
    end
  endtask

`ifdef HS32_WB_TIMEOUT_EN
  task automatic test_timeout();
    request(1'b0, 4'hF, 32'h0000_0500, 32'h0);
    tick();
    repeat (14) tick();
    checks++;
    if (wbs_ack_o !== 1'b0 || timeout !== 1'b0) begin
      failures++; $display("FAIL tmo_early got ack=%b timeout=%b exp 0 0", wbs_ack_o, timeout);
    end
    tick();
    checks++;
    if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'hDEAD_C0DE || timeout !== 1'b1) begin
      failures++; $display("FAIL tmo_resp got ack=%b dat=%h timeout=%b exp 1 deadc0de 1", wbs_ack_o, wbs_dat_o, timeout);
    end
    release_bus();
    tick();
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || timeout !== 1'b1) begin
      failures++; $display("FAIL tmo_sticky got busy=%b timeout=%b exp 0 1", busy, timeout);
    end
  endtask
`else
  task automatic test_timeout();
    checks++;
    if (timeout !== 1'b0) begin
      failures++; $display("FAIL tmo_tied got=%b exp=0", timeout);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat = 32'h0;
    m_dtr = 32'h0; m_ack = 1'b0;
    tick(); tick();
    test_reset();
    reset_n = 1'b1;
    tick();
    test_read();
    test_full_write();
    test_rmw();
    test_abort();
    test_back_to_back();
    test_sel_zero_and_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
